// File: rtl/regfile_pkg.sv
// Shared register-file constants and the debug-dump FSM state type.
package regfile_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } dump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// Sequential debug reader for the register file: walks indices in ascending
// order on the second read port and streams (index, data) beats over a
// valid/ready handshake. busy doubles as the core stall.
module regfile_dump #(
  parameter int XLEN     = regfile_pkg::XLEN,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter bit DUMP_X0  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [XLEN-1:0]   rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_idx,
  output logic [XLEN-1:0]   out_data,
  output logic              out_last
);
  import regfile_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] START_IDX = DUMP_X0 ? '0 : ADDR_W'(1);

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_idx_q, out_idx_d;
  logic [XLEN-1:0]   out_data_q, out_data_d;
  logic              out_last_q, out_last_d;

  // Next-state and registered-output logic for the dump walk.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = START_IDX;
          busy_d  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        // rf_data is the combinational read of idx_q this cycle; capture it.
        out_data_d  = rf_data;
        out_idx_d   = idx_q;
        out_last_d  = (idx_q == LAST_IDX);
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            // Gated by out_last, so idx never wraps.
            idx_d   = idx_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers; reset returns every output to idle values at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign rf_addr   = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Sequential debug reader for the RV32I register file. On a `start` pulse it walks the register indices in ascending order, drives each index onto the register file's read address, captures the 32-bit value, and streams it out as (index, data) beats over a valid/ready handshake. It sits beside the core on the register file's second read port, and the core is stalled while the dump is `busy`.

## Interface
- `XLEN`, default 32: data width of each register.
- `NUM_REGS`, default 32: number of architectural registers.
- `ADDR_W`, default 5: index width, equal to clog2(NUM_REGS).
- `DUMP_X0`, default 1: 1 means the dump starts at x0; 0 means it starts at x1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request a dump; sampled only in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted until the return to IDLE; used as the core stall.
- `done`  out  1  one-cycle pulse after the final beat is accepted.
- `rf_addr`  out  ADDR_W  register file read address.
- `rf_data`  in  XLEN  register file read data; combinational read of `rf_addr` in the same cycle.
- `out_valid`  out  1  a beat is presented.
- `out_ready`  in  1  the sink accepts the beat.
- `out_idx`  out  ADDR_W  register index of the beat.
- `out_data`  out  XLEN  register value of the beat.
- `out_last`  out  1  marks the beat for index NUM_REGS-1.

## Operation
- FSM states: IDLE, FETCH, SEND, DONE.
- IDLE:
  - If `start` is high, load `idx` with 0 (or 1 when DUMP_X0=0) and go to FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - `rf_addr` = `idx`.
  - On the edge, register `out_data` <= `rf_data`, `out_idx` <= `idx`, `out_last` <= (`idx` == NUM_REGS-1), `out_valid` <= 1.
  - Go to SEND.
- SEND:
  - Hold `out_valid`, `out_idx`, `out_data` and `out_last` stable until `out_valid` && `out_ready`.
  - On that handshake, clear `out_valid`.
  - If `out_last`, go to DONE. Otherwise increment `idx` and go to FETCH.
- DONE: `done` = 1 for this single cycle, then go to IDLE.
- `rf_addr` equals `idx` in every state. Its value outside FETCH is don't-care for the sink.
- `start` is ignored in FETCH, SEND and DONE. There is no queuing.
- `out_valid` never drops before its handshake. Once high, the beat is never retracted.
- `idx` is ADDR_W bits wide and never wraps: the increment is gated by `out_last`.
- Snapshot semantics:
  - Each value is the register content as read in its own FETCH cycle.
  - A write to the register file during a dump is visible only to indices fetched after that write.
  - Preventing such writes is the job of the core stall on `busy`, not of this block.
- x0 beat: carries whatever the register file returns for index 0.

## Timing
- Reset values: state IDLE, `idx` 0, `busy` 0, `done` 0, `out_valid` 0, `out_idx` 0, `out_data` 0, `out_last` 0.
- Reset asserted mid-dump: all outputs return to their reset values immediately. After `rst_n` deasserts, the block waits in IDLE for a new `start`.
- `start` sampled high at edge E0: FETCH during the following cycle, and `busy` rises at E0.
- First beat `out_valid` rises at E0+1.
- With `out_ready` held high:
  - One beat every 2 cycles.
  - The last handshake (for a 32-beat dump) is at E0+64.
  - `done` is high during the cycle after E0+64.
  - `busy` falls at E0+65.
- With DUMP_X0=0 there are 31 beats and the last handshake is at E0+62.
- Backpressure: each cycle with `out_ready` low extends the dump by exactly one cycle.
- `done` and `out_valid` are never high in the same cycle.

## Structure
- Shared package `regfile_pkg` holds:
  - constants XLEN, NUM_REGS, ADDR_W, shared with the register file;
  - the enum `dump_state_t` {IDLE, FETCH, SEND, DONE}.
- Single module, no sub-module. The output register is part of the FSM datapath and does not justify a separate block.

## Test plan
- Full dump: preload xk = 0x1000_0000 + k, hold `out_ready` = 1, pulse `start`.
  - Response: 32 beats in order, idx 0..31, data matching the preload (x0 = 0).
  - `out_last` only on idx 31; `done` one cycle after the handshake at E0+64.
- Backpressure: hold `out_ready` low for 3 cycles on beat idx 5.
  - Response: `out_idx`/`out_data` stay 5/0x1000_0005 and stable.
  - The dump ends 3 cycles later than the full-dump case.
- DUMP_X0=0: response is 31 beats, first idx 1, last idx 31, `done` after E0+62.
- `start` pulsed again during SEND at idx 10: ignored. Exactly one `done` and no duplicated beats.
- Reset mid-dump: assert `rst_n` low while at idx 12.
  - Response: `out_valid`, `busy` and `done` go to 0 immediately.
  - A later `start` restarts the dump from idx 0.
- Write during dump (stall bypassed): write x20 = 0xDEAD_BEEF while the dump is at idx 15.
  - Response: the beat for idx 20 carries 0xDEAD_BEEF.
